mem_ctrl: RTL and testbench

Arbiter and sequencer for the single byte-wide RAM port shared by instruction fetch (IF) and the data memory stage (MEM). Accepts one word fetch or one 1/2/4-byte load/store at a time and serialises it into per-byte RAM cycles. It assembles little-endian read data and returns a one-cycle done pulse to the owning requester. Sits between the IF/MEM stages and the external RAM; its done/busy signals feed the pipeline stall controller.

---
 rtl/mem_ctrl_pkg.sv | 42 ++++
 rtl/mem_ctrl_if.sv | 46 ++++
 rtl/mem_ctrl.sv | 124 ++++++++++++
 tb/tb_mem_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial RAM port controller.
// Holds bus widths, FSM state and size encodings, owner tags,
// reset/run-enable literals and a helper that converts a size code
// into the index of the last byte of the transfer.
package mem_ctrl_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned ByteW = 8;

  localparam logic RstActive = 1'b1;
  localparam logic RunEnable = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    SizeByte    = 2'b00,
    SizeHalf    = 2'b01,
    SizeWord    = 2'b10,
    SizeWordAlt = 2'b11
  } size_e;

  typedef enum logic {
    OwnIf,
    OwnMem
  } owner_e;

  // Index of the final byte (N-1); code 11 behaves as a word.
  function automatic logic [1:0] size_last(input logic [1:0] size);
    case (size)
      SizeByte: return 2'd0;
      SizeHalf: return 2'd1;
      default:  return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the requester (IF / MEM stage) and external RAM signals
// around mem_ctrl.
//   slave  : controller view (takes requests and ram_din, drives the rest)
//   master : environment view (pipeline stages plus RAM)
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  // instruction fetch
  logic             if_req;
  logic [AddrW-1:0] if_addr;
  logic [DataW-1:0] if_inst;
  logic             if_done;
  logic             branch_enable_i;
  // data memory stage
  logic             mem_req;
  logic             mem_we;
  logic [1:0]       mem_size;
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_wdata;
  logic [DataW-1:0] mem_rdata;
  logic             mem_done;
  // byte-wide RAM
  logic [AddrW-1:0] ram_a;
  logic [ByteW-1:0] ram_dout;
  logic             ram_wr;
  logic [ByteW-1:0] ram_din;
  // stall controller
  logic             busy;

  modport slave (
    input  if_req, if_addr, branch_enable_i,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  ram_din,
    output if_inst, if_done, mem_rdata, mem_done,
    output ram_a, ram_dout, ram_wr, busy
  );

  modport master (
    output if_req, if_addr, branch_enable_i,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output ram_din,
    input  if_inst, if_done, mem_rdata, mem_done,
    input  ram_a, ram_dout, ram_wr, busy
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbiter and byte sequencer for the single byte-wide RAM port shared by
// instruction fetch and the data memory stage. One transfer at a time:
// a 4-byte fetch or a 1/2/4-byte load/store, split into per-byte RAM
// cycles, with little-endian read assembly and a one-cycle done pulse.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   rdy  - run enable; low freezes every register and blocks RAM writes
//   bus  - mem_ctrl_if.slave: IF/MEM requests, RAM bus, done/busy
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic       rdy,
  mem_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [AddrW-1:0] base_q, base_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic [DataW-1:0] buf_q, buf_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       k_q, k_d;       // issue index
  logic [1:0]       r_q, r_d;       // receive index
  logic             rd_vld_q, rd_vld_d;  // ram_din carries a requested byte

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    last_d   = last_q;
    k_d      = k_q;
    r_d      = r_q;
    rd_vld_d = rd_vld_q;

    unique case (state_q)
      StIdle: begin
        // MEM wins: it belongs to the older instruction.
        if (bus.mem_req) begin
          owner_d = OwnMem;
          base_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          last_d  = size_last(bus.mem_size);
          state_d = bus.mem_we ? StWrite : StRead;
        end else if (bus.if_req) begin
          owner_d = OwnIf;
          base_d  = bus.if_addr;
          last_d  = size_last(SizeWord);
          state_d = StRead;
        end
        if (bus.mem_req || bus.if_req) begin
          k_d      = 2'd0;
          r_d      = 2'd0;
          rd_vld_d = 1'b0;
          buf_d    = '0;
        end
      end

      StRead: begin
        if (owner_q == OwnIf && bus.branch_enable_i) begin
          state_d = StIdle;
        end else begin
          if (k_q != last_q) k_d = k_q + 2'd1;
          // RAM answers one cycle after sampling the address.
          rd_vld_d = 1'b1;
          if (rd_vld_q) begin
            buf_d[{r_q, 3'b000} +: ByteW] = bus.ram_din;
            r_d = r_q + 2'd1;
            if (r_q == last_q) state_d = StDone;
          end
        end
      end

      StWrite: begin
        if (k_q == last_q) state_d = StDone;
        else               k_d     = k_q + 2'd1;
      end

      StDone:  state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstActive) begin
      state_q  <= StIdle;
      owner_q  <= OwnIf;
      base_q   <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      last_q   <= 2'd0;
      k_q      <= 2'd0;
      r_q      <= 2'd0;
      rd_vld_q <= 1'b0;
    end else if (rdy == RunEnable) begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      last_q   <= last_d;
      k_q      <= k_d;
      r_q      <= r_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // All outputs derive from registers, so they hold while rdy is low;
  // only the write strobe is gated.
  assign bus.busy      = (state_q != StIdle);
  assign bus.ram_a     = base_q + {{(AddrW-2){1'b0}}, k_q};
  assign bus.ram_dout  = wdata_q[{k_q, 3'b000} +: ByteW];
  assign bus.ram_wr    = (rdy == RunEnable) && (state_q == StWrite);
  assign bus.if_done   = (state_q == StDone) && (owner_q == OwnIf);
  assign bus.mem_done  = (state_q == StDone) && (owner_q == OwnMem);
  assign bus.if_inst   = buf_q;
  assign bus.mem_rdata = buf_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl. A byte-array reference memory
// predicts load/fetch data and store bytes; expected done events and RAM
// writes are queued at issue time and compared by independent monitors.
// The RAM model is gated by rdy, like the rest of the frozen pipeline.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
    bit          chk_data;
    int          idx;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  exp_t        sbq[$];
  wr_t         wq[$];
  logic [7:0]  ref_mem[1024];
  logic [7:0]  sim_ram[1024];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          act_cnt = 0;   // edges on which the block advanced
  int          wr_seen = 0;
  int          last_done = -1;
  bit          wr_chk_en = 1'b1;
  bit          rdy_rand = 1'b0;
  bit          rdy_hold = 1'b1;
  bit          init_go = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int len_of(input bit is_mem, input logic [1:0] size);
    if (!is_mem) return 4;
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[10'(a + 32'(i))];
    return v;
  endfunction

  // cycle and active-edge counters
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst && rdy) act_cnt++;
  end

  // byte RAM: synchronous read, frozen with the pipeline when rdy is low
  initial forever begin
    @(posedge clk);
    if (init_go) begin
      for (int i = 0; i < 1024; i++) sim_ram[i] <= ref_mem[i];
    end else if (rdy) begin
      if (bus.ram_wr) sim_ram[bus.ram_a[9:0]] <= bus.ram_dout;
      bus.ram_din <= sim_ram[bus.ram_a[9:0]];
    end
  end

  initial forever begin
    @(negedge clk);
    rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_hold;
  end

  // done monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && (bus.if_done || bus.mem_done) && act_cnt != last_done) begin
        last_done = act_cnt;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got if_done=%b mem_done=%b expected none",
                   bus.if_done, bus.mem_done);
        end else begin
          e = sbq.pop_front();
          chk("done_owner", 32'({bus.if_done, bus.mem_done}), e.is_mem ? 32'd1 : 32'd2);
          if (e.chk_data)
            chk("done_data", e.is_mem ? bus.mem_rdata : bus.if_inst, e.data);
          chk("done_time", 32'(act_cnt), 32'(e.idx));
        end
      end
    end
  end

  // RAM write monitor
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && bus.ram_wr) begin
        wr_seen++;
        if (wr_chk_en) begin
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got a=%h d=%h expected no write",
                     bus.ram_a, bus.ram_dout);
          end else begin
            w = wq.pop_front();
            chk("wr_addr", bus.ram_a, w.a);
            chk("wr_data", 32'(bus.ram_dout), 32'(w.d));
          end
        end
      end
    end
  end

  task automatic issue(input bit is_mem, input bit we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int acc_cyc, output int w0);
    int n;
    bit got = 1'b0;
    n = len_of(is_mem, size);
    @(negedge clk);
    if (is_mem) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = we;
      bus.mem_size  = size;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      if (rdy) got = 1'b1;
    end
    #1;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no active edge expected acceptance");
    end
    acc_cyc = cyc;
    w0 = wr_seen;
    if (is_mem && we) begin
      for (int i = 0; i < n; i++) begin
        ref_mem[10'(addr + 32'(i))] = wdata[8*i +: 8];
        wq.push_back('{addr + 32'(i), wdata[8*i +: 8]});
      end
    end
    sbq.push_back('{is_mem, (is_mem && we) ? 32'h0 : ref_read(addr, n), !(is_mem && we),
                    act_cnt + ((is_mem && we) ? n : n + 1)});
  endtask

  // Waits for the done pulse, drops requests, then for the edge leaving DONE.
  task automatic wait_done_drop(output int done_cyc, input bit noise);
    bit got = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (bus.if_done || bus.mem_done) begin
        got = 1'b1;
        done_cyc = cyc;
      end else if (noise) begin
        bus.branch_enable_i = ($urandom_range(0, 3) == 0);
      end
    end
    bus.if_req = 1'b0;
    bus.mem_req = 1'b0;
    bus.branch_enable_i = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected a done pulse");
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      if (rdy) got = 1'b1;
    end
  endtask

  task automatic do_op(input bit is_mem, input bit we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    int acc_cyc, w0, dc;
    issue(is_mem, we, size, addr, wdata, acc_cyc, w0);
    wait_done_drop(dc, is_mem);
    lat = dc - acc_cyc;
    chk("wr_count", 32'(wr_seen - w0), (is_mem && we) ? 32'(len_of(is_mem, size)) : 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_if_done"}, 32'(bus.if_done), 32'd0);
    chk({tag, "_mem_done"}, 32'(bus.mem_done), 32'd0);
    chk({tag, "_ram_wr"}, 32'(bus.ram_wr), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_ram_a"}, bus.ram_a, 32'd0);
    chk({tag, "_ram_dout"}, 32'(bus.ram_dout), 32'd0);
    chk({tag, "_if_inst"}, bus.if_inst, 32'd0);
    chk({tag, "_mem_rdata"}, bus.mem_rdata, 32'd0);
  endtask

  initial begin
    int lat, acc, acc_c, dc, w0;
    bit got;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.branch_enable_i = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_size = 2'b00;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    ref_mem[10'h100] = 8'h13;
    ref_mem[10'h101] = 8'h05;
    ref_mem[10'h102] = 8'h10;
    ref_mem[10'h103] = 8'h00;
    ref_mem[10'h200] = 8'hAB;
    init_go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init_go = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

    // word fetch
    do_op(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, lat);
    chk("fetch_latency", 32'(lat), 32'd5);

    // simultaneous requests: MEM byte load first, IF after MEM leaves DONE
    @(negedge clk);
    bus.mem_req = 1'b1;
    bus.mem_we = 1'b0;
    bus.mem_size = 2'b00;
    bus.mem_addr = 32'h200;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    @(posedge clk);
    #1;
    acc = act_cnt;
    sbq.push_back('{1'b1, ref_read(32'h200, 1), 1'b1, acc + 2});
    sbq.push_back('{1'b0, ref_read(32'h100, 4), 1'b1, acc + 9});
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.mem_done) got = 1'b1;
    end
    bus.mem_req = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL contention_mem: got no mem_done expected mem_done");
    end
    wait_done_drop(dc, 1'b0);

    // word store then read-backs
    do_op(1'b1, 1'b1, 2'b10, 32'h300, 32'hDEADBEEF, lat);
    chk("store_latency", 32'(lat), 32'd4);
    do_op(1'b1, 1'b0, 2'b11, 32'h300, 32'h0, lat);
    chk("load_word_latency", 32'(lat), 32'd5);
    do_op(1'b1, 1'b0, 2'b00, 32'h302, 32'h0, lat);
    chk("load_byte_latency", 32'(lat), 32'd2);

    // flush of an in-flight fetch at E2, refetch accepted on the next edge
    @(negedge clk);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.branch_enable_i = 1'b1;
    bus.if_addr = 32'h104;
    @(posedge clk);
    @(negedge clk);
    bus.branch_enable_i = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    acc_c = cyc;
    sbq.push_back('{1'b0, ref_read(32'h104, 4), 1'b1, act_cnt + 5});
    wait_done_drop(dc, 1'b0);
    chk("refetch_latency", 32'(dc - acc_c), 32'd5);

    // half load with rdy low for three cycles after E1
    @(negedge clk);
    bus.mem_req = 1'b1;
    bus.mem_we = 1'b0;
    bus.mem_size = 2'b01;
    bus.mem_addr = 32'h80;
    @(posedge clk);
    #1;
    acc_c = cyc;
    sbq.push_back('{1'b1, ref_read(32'h80, 2), 1'b1, act_cnt + 3});
    @(posedge clk);
    #1;
    rdy_hold = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_ram_a", bus.ram_a, 32'h81);
    chk("stall_ram_wr", 32'(bus.ram_wr), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rdy_hold = 1'b1;
    wait_done_drop(dc, 1'b0);
    chk("stall_latency", 32'(dc - acc_c), 32'd6);

    // randomized traffic with rdy stalls and ignored flushes during MEM
    rdy_rand = 1'b1;
    for (int t = 0; t < 60; t++) begin
      int kind;
      logic [1:0] sz;
      logic [31:0] ad;
      kind = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      ad = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
      do_op(kind != 0, kind == 2, sz, ad, $urandom, lat);
    end
    rdy_rand = 1'b0;
    @(posedge clk);
    @(posedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    chk("wq_empty", 32'(wq.size()), 32'd0);

    // reset in the middle of a word store
    wr_chk_en = 1'b0;
    @(negedge clk);
    bus.mem_req = 1'b1;
    bus.mem_we = 1'b1;
    bus.mem_size = 2'b10;
    bus.mem_addr = 32'h40;
    bus.mem_wdata = 32'h1234_5678;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("store_active", 32'(bus.ram_wr), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("midreset");
    rst = 1'b0;
    bus.mem_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_busy", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
